wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline interface: consumes the MEM/WB register outputs, selects write-back data, and commits it to a 32-entry general-purpose register file.
- Provides the two combinational read ports used by the ID stage.
- Also provides a registered write-back trace and a retired-write counter for bench and debug observation.

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width (2**ADDR_W entries, entry 0 hardwired zero)
- CNT_W, 32, width of retired-write counter

Ports:
- CLK  input  1  clock; all state updates on posedge
- RST  input  1  synchronous reset, active-high
- RegWrite  input  1  write-back enable from MEM/WB
- MemtoReg  input  1  1 selects ReadData, 0 selects ALUOut
- ALUOut  input  DATA_W  ALU result from MEM/WB
- ReadData  input  DATA_W  memory load data from MEM/WB
- WriteReg  input  ADDR_W  destination register index
- ReadReg1  input  ADDR_W  ID-stage source index, port 1
- ReadReg2  input  ADDR_W  ID-stage source index, port 2
- ReadData1  output  DATA_W  register contents, port 1 (combinational)
- ReadData2  output  DATA_W  register contents, port 2 (combinational)
- WBData  output  DATA_W  selected write-back data (combinational)
- TraceValid  output  1  registered: a write committed on the previous edge
- TraceReg  output  ADDR_W  registered: index of that write
- TraceData  output  DATA_W  registered: data of that write
- WriteCount  output  CNT_W  registered: number of committed writes

Behaviour:
- Reset: RST sampled high on posedge clears all entries 1..2**ADDR_W-1 to 0. It also clears TraceValid, TraceReg, TraceData and WriteCount to 0.
- Reset and write coincidence: RST has priority over any simultaneous write. The write is dropped, not counted and not traced.
- WBData = MemtoReg ? ReadData : ALUOut. Purely combinational; valid regardless of RegWrite.
- Commit condition: commit = RegWrite && (WriteReg != 0) && !RST.
- On posedge with commit: entry[WriteReg] <= WBData; WriteCount <= WriteCount + 1.
- WriteCount wraps modulo 2**CNT_W; the increment from all-ones gives 0.
- Trace registers update every non-reset edge: TraceValid <= commit; TraceReg <= WriteReg; TraceData <= WBData. TraceReg and TraceData are don't-care when TraceValid=0 but must still be deterministic.
- Write to entry 0: ignored. Entry 0 always reads 0. No count, TraceValid=0.
- Read ports: ReadDataN = 0 if ReadRegN == 0, else entry[ReadRegN] (subject to the bypass below). No read latency.
- Both read ports may address the same entry; both return identical data.
- Single write port only. No other state machine; state is the array, trace registers and counter.
- Mid-operation reset: an in-flight MEM/WB write on the reset edge is lost. Register contents after reset are all zero irrespective of history.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN.
- Defined: same-cycle write-through bypass. If commit-qualifying (RegWrite && WriteReg != 0 && !RST) and ReadRegN == WriteReg, then ReadDataN = WBData in the same cycle, before the edge. This removes the WB->ID structural hazard.
- Not defined: ReadDataN always shows the stored entry. The new value is visible only after the committing edge; the hazard unit must stall or forward instead.
- Entry 0 reads 0 in both builds.

Test Plan:
- Reset: write x5=0xDEADBEEF, then assert RST one cycle -> ReadData1 (ReadReg1=5)=0, WriteCount=0, TraceValid=0.
- Mux and commit: RegWrite=1, MemtoReg=0, ALUOut=0x12345678, WriteReg=3, edge, then MemtoReg=1, ReadData=0xCAFEF00D, WriteReg=4, edge -> x3=0x12345678, x4=0xCAFEF00D, WriteCount=2, trace after second edge shows (1,4,0xCAFEF00D).
- Zero register: RegWrite=1, WriteReg=0, ALUOut=0xFFFFFFFF, edge -> ReadData2 (ReadReg2=0)=0, WriteCount unchanged, TraceValid=0.
- Bypass: x7=0x1, then present RegWrite=1, WriteReg=7, ALUOut=0x2 with ReadReg1=7 before the edge -> ReadData1=0x2 with WB_REGFILE_BYPASS_EN, 0x1 without; 0x2 after the edge in both builds.
- Reset vs write: RST=1 and RegWrite=1, WriteReg=9, ALUOut=0x55 on the same edge -> x9=0, WriteCount=0.
- Counter wrap (CNT_W=4 build): 16 committing writes -> WriteCount returns to 0; the 17th gives 1.

Source files
------------

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MEM/WB write-back select, 32-entry register file, trace and retired-write counter
// Optional same-cycle write-through bypass on the read ports: WB_REGFILE_BYPASS_EN
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] ReadData,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] WBData,
    output logic              TraceValid,
    output logic [ADDR_W-1:0] TraceReg,
    output logic [DATA_W-1:0] TraceData,
    output logic [CNT_W-1:0]  WriteCount
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [0:NUM_REGS-1];
    logic              commit;

    assign WBData = MemtoReg ? ReadData : ALUOut;
    // Reset wins over a coincident write; entry 0 is never a real destination.
    assign commit = RegWrite && (WriteReg != '0) && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            TraceValid <= 1'b0;
            TraceReg   <= '0;
            TraceData  <= '0;
            WriteCount <= '0;
        end else begin
            if (commit) begin
                regs[WriteReg] <= WBData;
                WriteCount     <= WriteCount + CNT_W'(1);
            end
            TraceValid <= commit;
            TraceReg   <= WriteReg;
            TraceData  <= WBData;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] sel);
        logic [DATA_W-1:0] val;
        val = regs[sel];
`ifdef WB_REGFILE_BYPASS_EN
        if (commit && (sel == WriteReg)) begin
            val = WBData;
        end
`endif
        if (sel == '0) begin
            val = '0;
        end
        return val;
    endfunction

    always_comb begin
        ReadData1 = read_port(ReadReg1);
        ReadData2 = read_port(ReadReg2);
    end
endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - vector table, hand sequences and randomized model check for wb_regfile
module tb_wb_regfile;
    logic        CLK = 1'b0;
    logic        RST, RegWrite, MemtoReg;
    logic [31:0] ALUOut, ReadData;
    logic [4:0]  WriteReg, ReadReg1, ReadReg2;
    logic [31:0] ReadData1, ReadData2, WBData, TraceData, WriteCount;
    logic        TraceValid;
    logic [4:0]  TraceReg;

    logic [31:0] s_rd1, s_rd2, s_wb, s_td;
    logic        s_tv;
    logic [4:0]  s_treg;
    logic [3:0]  s_cnt;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] mregs [32];
    int unsigned mcnt;
    logic        mtv;
    logic [4:0]  mtreg;
    logic [31:0] mtd;

    always #5 CLK = ~CLK;

    wb_regfile dut (
        .CLK(CLK), .RST(RST), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .ALUOut(ALUOut), .ReadData(ReadData), .WriteReg(WriteReg),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .WBData(WBData),
        .TraceValid(TraceValid), .TraceReg(TraceReg), .TraceData(TraceData),
        .WriteCount(WriteCount)
    );

    wb_regfile #(.CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .ALUOut(ALUOut), .ReadData(ReadData), .WriteReg(WriteReg),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(s_rd1), .ReadData2(s_rd2), .WBData(s_wb),
        .TraceValid(s_tv), .TraceReg(s_treg), .TraceData(s_td),
        .WriteCount(s_cnt)
    );

    typedef struct {
        logic        rst, rw, m2r;
        logic [31:0] alu, rd;
        logic [4:0]  wr, r1, r2;
        logic [31:0] e_r1, e_r2;
        logic        e_tv;
        logic [4:0]  e_treg;
        logic [31:0] e_td, e_cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic rst_i, input logic rw_i, input logic m2r_i,
                         input logic [31:0] alu_i, input logic [31:0] rd_i,
                         input logic [4:0] wr_i, input logic [4:0] r1_i, input logic [4:0] r2_i);
        @(negedge CLK);
        RST = rst_i; RegWrite = rw_i; MemtoReg = m2r_i; ALUOut = alu_i; ReadData = rd_i;
        WriteReg = wr_i; ReadReg1 = r1_i; ReadReg2 = r2_i;
        #1;
    endtask

    // Register-file semantics in plain terms: a list of 32 values, a counter and the last write.
    task automatic clock_edge();
        logic [31:0] wb;
        @(posedge CLK);
        wb = MemtoReg ? ReadData : ALUOut;
        if (RST) begin
            foreach (mregs[i]) mregs[i] = 0;
            mcnt = 0; mtv = 0; mtreg = 0; mtd = 0;
        end else begin
            mtv = RegWrite && WriteReg != 0;
            if (mtv) begin
                mregs[WriteReg] = wb;
                mcnt++;
            end
            mtreg = WriteReg;
            mtd = wb;
        end
        #1;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] sel);
        if (sel == 0) return 0;
`ifdef WB_REGFILE_BYPASS_EN
        if (RegWrite && !RST && WriteReg == sel) return MemtoReg ? ReadData : ALUOut;
`endif
        return mregs[sel];
    endfunction

    vec_t vecs[7];

    initial begin
        vecs[0] = '{0, 1, 0, 32'hDEADBEEF, 0, 5, 5, 0, 32'hDEADBEEF, 0, 1, 5, 32'hDEADBEEF, 1};
        vecs[1] = '{1, 0, 0, 0, 0, 0, 5, 5, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{0, 1, 0, 32'h12345678, 0, 3, 3, 0, 32'h12345678, 0, 1, 3, 32'h12345678, 1};
        vecs[3] = '{0, 1, 1, 0, 32'hCAFEF00D, 4, 3, 4, 32'h12345678, 32'hCAFEF00D, 1, 4, 32'hCAFEF00D, 2};
        vecs[4] = '{0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 2};
        vecs[5] = '{0, 0, 0, 32'h0000AAAA, 0, 3, 3, 4, 32'h12345678, 32'hCAFEF00D, 0, 3, 32'h0000AAAA, 2};
        vecs[6] = '{1, 1, 0, 32'h00000055, 0, 9, 9, 3, 0, 0, 0, 0, 0, 0};

        apply(1, 0, 0, 0, 0, 0, 0, 0);
        clock_edge();
        clock_edge();
        check("reset_count", WriteCount, 0);
        check("reset_tvalid", {31'b0, TraceValid}, 0);
        check("reset_tdata", TraceData, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].rw, vecs[i].m2r, vecs[i].alu, vecs[i].rd,
                  vecs[i].wr, vecs[i].r1, vecs[i].r2);
            check($sformatf("v%0d_wbdata", i), WBData, vecs[i].m2r ? vecs[i].rd : vecs[i].alu);
            clock_edge();
            check($sformatf("v%0d_rd1", i), ReadData1, vecs[i].e_r1);
            check($sformatf("v%0d_rd2", i), ReadData2, vecs[i].e_r2);
            check($sformatf("v%0d_tvalid", i), {31'b0, TraceValid}, {31'b0, vecs[i].e_tv});
            check($sformatf("v%0d_treg", i), {27'b0, TraceReg}, {27'b0, vecs[i].e_treg});
            check($sformatf("v%0d_tdata", i), TraceData, vecs[i].e_td);
            check($sformatf("v%0d_count", i), WriteCount, vecs[i].e_cnt);
        end

        // Write-through bypass corner: new value visible before the edge only when enabled.
        apply(0, 1, 0, 32'h1, 0, 7, 7, 0);
        clock_edge();
        apply(0, 1, 0, 32'h2, 0, 7, 7, 0);
`ifdef WB_REGFILE_BYPASS_EN
        check("bypass_pre", ReadData1, 32'h2);
`else
        check("bypass_pre", ReadData1, 32'h1);
`endif
        clock_edge();
        check("bypass_post", ReadData1, 32'h2);
        apply(0, 1, 0, 32'h5, 0, 0, 0, 0);
        check("bypass_x0", ReadData1, 0);
        clock_edge();

        // Counter wrap on the 4-bit instance.
        apply(1, 0, 0, 0, 0, 0, 0, 0);
        clock_edge();
        for (int i = 0; i < 16; i++) begin
            apply(0, 1, 0, i, 0, 5'(1 + i % 31), 0, 0);
            clock_edge();
        end
        check("wrap16_cnt4", {28'b0, s_cnt}, 0);
        check("wrap16_cnt32", WriteCount, 16);
        apply(0, 1, 0, 32'h77, 0, 5'd20, 5'd20, 0);
        clock_edge();
        check("wrap17_cnt4", {28'b0, s_cnt}, 1);
        check("wrap17_cnt32", WriteCount, 17);

        apply(1, 0, 0, 0, 0, 0, 0, 0);
        clock_edge();
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                  $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
            check("rnd_wbdata", WBData, MemtoReg ? ReadData : ALUOut);
            check("rnd_rd1_pre", ReadData1, exp_read(ReadReg1));
            check("rnd_rd2_pre", ReadData2, exp_read(ReadReg2));
            clock_edge();
            check("rnd_tvalid", {31'b0, TraceValid}, {31'b0, mtv});
            check("rnd_treg", {27'b0, TraceReg}, {27'b0, mtreg});
            check("rnd_tdata", TraceData, mtd);
            check("rnd_count", WriteCount, mcnt);
            check("rnd_cnt4", {28'b0, s_cnt}, mcnt % 16);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
